// File: rtl/mdio_frame_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_frame_pkg                                              |
// | Purpose  : Shared MDIO frame constants, opcodes and FSM state encoding |
// | Contents : C_PREAMBLE_LEN, C_OP_READ, C_OP_WRITE, state_t, field_last  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package mdio_frame_pkg;

    localparam int unsigned C_PREAMBLE_LEN = 32;
    localparam logic [1:0]  C_OP_READ      = 2'b10;
    localparam logic [1:0]  C_OP_WRITE     = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ST    = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_DATA  = 4'd6,
        S_WACK  = 4'd7
    } state_t;

    // Index of the last bit of the multi-bit field handled in a given state.
    function automatic logic [3:0] field_last(input state_t s);
        case (s)
            S_OP, S_TA:       field_last = 4'd1;
            S_PHYAD, S_REGAD: field_last = 4'd4;
            S_DATA:           field_last = 4'd15;
            default:          field_last = 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mdio_frame                                                  |
// | Purpose  : MDIO (clause 22) slave frame decoder bridging to a simple   |
// |            register bus. Answers frames addressed to PHY_ADDR.         |
// | Ports    : clk, rst_n      - clock, async active-low reset             |
// |            ce, mdi         - MDC rising-edge strobe and sampled MDIO   |
// |            mdo, mdo_valid  - MDIO drive value and output enable        |
// |            reg_stb/we/addr/wdata - register bus request (held to ack)  |
// |            reg_ack/err/rdata     - register bus completion             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mdio_frame
    import mdio_frame_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdo_valid,
    output logic        reg_stb,
    output logic        reg_we,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    input  logic        reg_ack,
    input  logic        reg_err,
    input  logic [15:0] reg_rdata
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_pre_cnt;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_shreg;      // address/opcode capture, write data in, read data out
    logic        r_rd;
    logic        r_data_ok;    // good read data sits in r_shreg
    logic        r_stb;
    logic        r_we;
    logic [4:0]  r_addr;
    logic        r_mdo;
    logic        r_mdo_valid;

    logic        w_last;
    logic        w_in_field;
    logic        w_pre_full;
    logic        w_op_ok;
    logic        w_ack;
    logic [15:0] w_word;

    assign w_last     = (r_bit_cnt == field_last(r_state));
    assign w_in_field = (r_state == S_OP) || (r_state == S_PHYAD) || (r_state == S_REGAD) ||
                        (r_state == S_TA) || (r_state == S_DATA);
    assign w_pre_full = (r_pre_cnt == 6'(C_PREAMBLE_LEN));
    assign w_word     = {r_shreg[14:0], mdi};
    assign w_op_ok    = (w_word[1:0] == C_OP_READ) || (w_word[1:0] == C_OP_WRITE);
    // An ack without an outstanding request is meaningless and is dropped.
    assign w_ack      = r_stb & reg_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ce && !mdi && w_pre_full) w_state_nxt = S_ST;
            S_ST:    if (ce) w_state_nxt = mdi ? S_OP : S_IDLE;
            S_OP:    if (ce && w_last) w_state_nxt = w_op_ok ? S_PHYAD : S_IDLE;
            S_PHYAD: if (ce && w_last) w_state_nxt = (w_word[4:0] == PHY_ADDR) ? S_REGAD : S_IDLE;
            // A stale request (late ack after an aborted read) still pending
            // here would make a second outstanding request, so drop the frame.
            S_REGAD: if (ce && w_last) w_state_nxt = r_stb ? S_IDLE : S_TA;
            S_TA:    if (ce && w_last) w_state_nxt = (r_rd && !r_data_ok) ? S_IDLE : S_DATA;
            S_DATA:  if (ce && w_last) w_state_nxt = r_rd ? S_IDLE : S_WACK;
            S_WACK:  if (w_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_rd        <= 1'b0;
            r_data_ok   <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_mdo       <= 1'b0;
            r_mdo_valid <= 1'b0;
        end else begin
            if (w_ack) r_stb <= 1'b0;
            // Leaving IDLE always restarts preamble counting from zero.
            if (r_state != S_IDLE) r_pre_cnt <= '0;
            if (r_state == S_IDLE) r_data_ok <= 1'b0;
            // Read data is only accepted while its own frame waits in TA.
            if (r_state == S_TA && w_ack && !reg_err) begin
                r_shreg   <= reg_rdata;
                r_data_ok <= 1'b1;
            end

            if (ce) begin
                if (w_in_field) r_bit_cnt <= w_last ? 4'd0 : r_bit_cnt + 4'd1;
                case (r_state)
                    S_IDLE: begin
                        if (mdi) begin
                            if (!w_pre_full) r_pre_cnt <= r_pre_cnt + 6'd1;
                        end else if (!w_pre_full) begin
                            r_pre_cnt <= '0;
                        end
                    end
                    S_OP: begin
                        r_shreg <= w_word;
                        if (w_last) r_rd <= (w_word[1:0] == C_OP_READ);
                    end
                    S_PHYAD: r_shreg <= w_word;
                    S_REGAD: begin
                        r_shreg <= w_word;
                        if (w_last && !r_stb) begin
                            r_addr <= w_word[4:0];
                            if (r_rd) begin
                                r_stb <= 1'b1;
                                r_we  <= 1'b0;
                            end
                        end
                    end
                    S_TA: begin
                        if (r_rd) begin
                            if (!w_last) begin
                                // Second TA bit is driven low only if data is ready.
                                r_mdo_valid <= r_data_ok;
                                r_mdo       <= 1'b0;
                            end else if (r_data_ok) begin
                                r_mdo_valid <= 1'b1;
                                r_mdo       <= r_shreg[15];
                                r_shreg     <= {r_shreg[14:0], 1'b0};
                            end else begin
                                r_mdo_valid <= 1'b0;
                                r_mdo       <= 1'b0;
                            end
                        end
                    end
                    S_DATA: begin
                        if (r_rd) begin
                            if (w_last) begin
                                r_mdo_valid <= 1'b0;
                                r_mdo       <= 1'b0;
                            end else begin
                                r_mdo   <= r_shreg[15];
                                r_shreg <= {r_shreg[14:0], 1'b0};
                            end
                        end else begin
                            r_shreg <= w_word;
                            if (w_last) begin
                                r_stb <= 1'b1;
                                r_we  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mdo       = r_mdo;
    assign mdo_valid = r_mdo_valid;
    assign reg_stb   = r_stb;
    assign reg_we    = r_we;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_shreg;

endmodule
`default_nettype wire

// File: tb/tb_mdio_frame.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mdio_frame                                               |
// | Purpose  : Directed self-checking bench for mdio_frame                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mdio_frame;

    localparam logic [4:0] PHY = 5'h05;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        mdi;
    logic        mdo;
    logic        mdo_valid;
    logic        reg_stb;
    logic        reg_we;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic        reg_err;
    logic [15:0] reg_rdata;

    int total = 0;
    int bad   = 0;

    // Register-bus responder controls and observations
    logic        ack_en    = 1'b1;
    int          ack_delay = 1;
    logic        ack_err   = 1'b0;
    logic [15:0] rdata_q   = 16'h0000;
    int          stb_cnt   = 0;
    int          req_cnt   = 0;
    int          last_hold = 0;
    logic [4:0]  last_addr = 5'h00;
    logic        last_we   = 1'b0;
    logic [15:0] last_wdata = 16'h0000;
    logic        valid_seen = 1'b0;

    mdio_frame #(.PHY_ADDR(PHY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .mdi       (mdi),
        .mdo       (mdo),
        .mdo_valid (mdo_valid),
        .reg_stb   (reg_stb),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_ack   (reg_ack),
        .reg_err   (reg_err),
        .reg_rdata (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Responder: acks ack_delay clocks after reg_stb is first seen
    initial begin
        reg_ack   = 1'b0;
        reg_err   = 1'b0;
        reg_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            reg_ack = 1'b0;
            reg_err = 1'b0;
            if (reg_stb) begin
                if (stb_cnt == 0) begin
                    req_cnt++;
                    last_addr  = reg_addr;
                    last_we    = reg_we;
                    last_wdata = reg_wdata;
                end
                stb_cnt++;
                if (ack_en && stb_cnt >= ack_delay) begin
                    reg_ack   = 1'b1;
                    reg_err   = ack_err;
                    reg_rdata = rdata_q;
                end
            end else begin
                if (stb_cnt > 0) last_hold = stb_cnt;
                stb_cnt = 0;
            end
            if (mdo_valid) valid_seen = 1'b1;
        end
    end

    // One MDC period: ce for one clk, 4 clks per bit; samples outputs after the ce
    task automatic send_bit(input logic b, output logic o, output logic v);
        @(negedge clk);
        ce  = 1'b1;
        mdi = b;
        @(negedge clk);
        o  = mdo;
        v  = mdo_valid;
        ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_ones(input int n);
        logic o, v;
        for (int i = 0; i < n; i++) send_bit(1'b1, o, v);
    endtask

    task automatic send_hdr(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
        logic o, v;
        logic [13:0] h;
        h = {2'b01, op, phy, ra};
        for (int i = 13; i >= 0; i--) send_bit(h[i], o, v);
    endtask

    task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] rd,
                           input logic expect_ok, input int exp_req, input logic exp_stb_end,
                           input string name);
        logic o, v;
        logic [17:0] vv, mm;
        int req0;
        req0    = req_cnt;
        rdata_q = rd;
        send_ones(32);
        valid_seen = 1'b0;
        send_hdr(2'b10, phy, ra);
        for (int i = 0; i < 18; i++) begin
            send_bit(1'b1, o, v);
            vv[17-i] = v;
            mm[17-i] = o;
        end
        total++;
        if (req_cnt !== req0 + exp_req) begin
            bad++;
            $display("FAIL %s_req: got %0d want %0d", name, req_cnt - req0, exp_req);
        end
        total++;
        if (reg_stb !== exp_stb_end) begin
            bad++;
            $display("FAIL %s_stb_end: got %b want %b", name, reg_stb, exp_stb_end);
        end
        if (expect_ok) begin
            total++;
            if ({last_addr, last_we} !== {ra, 1'b0}) begin
                bad++;
                $display("FAIL %s_addr: got %h/%b want %h/0", name, last_addr, last_we, ra);
            end
            total++;
            if (vv !== 18'h3FFFE) begin
                bad++;
                $display("FAIL %s_valid: got %b want %b", name, vv, 18'h3FFFE);
            end
            total++;
            if (mm !== {1'b0, rd, 1'b0}) begin
                bad++;
                $display("FAIL %s_bits: got %b want %b", name, mm, {1'b0, rd, 1'b0});
            end
        end else begin
            total++;
            if (valid_seen !== 1'b0) begin
                bad++;
                $display("FAIL %s_mdo_valid: got 1 want 0", name);
            end
        end
    endtask

    task automatic do_write(input logic [4:0] ra, input logic [15:0] wd);
        logic o, v;
        send_ones(32);
        send_hdr(2'b01, PHY, ra);
        send_bit(1'b1, o, v);
        send_bit(1'b0, o, v);
        for (int i = 15; i >= 0; i--) send_bit(wd[i], o, v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        mdi   = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({mdo, mdo_valid, reg_stb, reg_we, reg_addr, reg_wdata} !== 25'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {mdo, mdo_valid, reg_stb, reg_we, reg_addr, reg_wdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        ack_en = 1'b1; ack_delay = 1; ack_err = 1'b0;
        do_read(PHY, 5'h02, 16'hABCD, 1'b1, 1, 1'b0, "read_abcd");
    endtask

    task automatic test_write();
        int req0;
        int n;
        ack_en = 1'b1; ack_delay = 8; ack_err = 1'b0;
        req0 = req_cnt;
        do_write(5'h1F, 16'h1234);
        total++;
        if ({reg_stb, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, 5'h1F, 16'h1234}) begin
            bad++;
            $display("FAIL write_req: got %b/%b/%h/%h want 1/1/1f/1234",
                     reg_stb, reg_we, reg_addr, reg_wdata);
        end
        n = 0;
        while (reg_stb && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (reg_stb !== 1'b0) begin
            bad++;
            $display("FAIL write_stb_drop: got 1 want 0 within 40 clks");
        end
        total++;
        if (req_cnt !== req0 + 1 || last_hold !== 8) begin
            bad++;
            $display("FAIL write_single_hold: got req=%0d hold=%0d want req=1 hold=8",
                     req_cnt - req0, last_hold);
        end
        ack_delay = 1;
    endtask

    task automatic test_back_to_back();
        do_read(PHY, 5'h1F, 16'h8001, 1'b1, 1, 1'b0, "b2b_read");
    endtask

    task automatic test_wrong_phy();
        do_read(PHY ^ 5'h01, 5'h02, 16'h1111, 1'b0, 0, 1'b0, "wrong_phy");
        do_read(PHY, 5'h0A, 16'h5A5A, 1'b1, 1, 1'b0, "after_wrong_phy");
    endtask

    task automatic test_short_pre();
        logic o, v;
        int req0;
        req0 = req_cnt;
        send_bit(1'b0, o, v);
        send_ones(31);
        valid_seen = 1'b0;
        send_hdr(2'b10, PHY, 5'h03);
        send_ones(18);
        total++;
        if (req_cnt !== req0 || valid_seen !== 1'b0) begin
            bad++;
            $display("FAIL short_pre: got req=%0d valid=%b want req=0 valid=0",
                     req_cnt - req0, valid_seen);
        end
    endtask

    task automatic test_abort_noack();
        int n;
        ack_en = 1'b0; ack_delay = 1; ack_err = 1'b0;
        do_read(PHY, 5'h04, 16'hFFFF, 1'b0, 1, 1'b1, "noack");
        ack_en = 1'b1;
        n = 0;
        while (reg_stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (reg_stb !== 1'b0) begin
            bad++;
            $display("FAIL noack_late_drop: got 1 want 0 within 20 clks");
        end
        do_read(PHY, 5'h06, 16'h0F0F, 1'b1, 1, 1'b0, "after_noack");
    endtask

    task automatic test_abort_err();
        ack_en = 1'b1; ack_delay = 1; ack_err = 1'b1;
        do_read(PHY, 5'h07, 16'hBEEF, 1'b0, 1, 1'b0, "err");
        ack_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic o, v;
        int req0;
        ack_en = 1'b1; ack_delay = 1; ack_err = 1'b0;
        rdata_q = 16'hC3C3;
        send_ones(32);
        send_hdr(2'b10, PHY, 5'h09);
        for (int i = 0; i < 10; i++) send_bit(1'b1, o, v);
        total++;
        if (mdo_valid !== 1'b1 || mdo !== 1'b1) begin
            bad++;
            $display("FAIL mid_read_driving: got %b/%b want 1/1", mdo_valid, mdo);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mdo_valid, mdo, reg_stb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_read: got %b want 000", {mdo_valid, mdo, reg_stb});
        end
        @(negedge clk);
        rst_n = 1'b1;

        ack_en = 1'b0;
        do_write(5'h11, 16'h0001);
        total++;
        if (reg_stb !== 1'b1) begin
            bad++;
            $display("FAIL mid_write_stb: got %b want 1", reg_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({reg_stb, reg_we, reg_wdata} !== 18'h0) begin
            bad++;
            $display("FAIL reset_mid_write: got %h want 0", {reg_stb, reg_we, reg_wdata});
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;

        // Frame with no preamble after reset release is ignored
        req0 = req_cnt;
        valid_seen = 1'b0;
        send_hdr(2'b10, PHY, 5'h0C);
        send_bit(1'b0, o, v);
        total++;
        if (req_cnt !== req0 || valid_seen !== 1'b0) begin
            bad++;
            $display("FAIL no_pre_after_reset: got req=%0d valid=%b want 0/0",
                     req_cnt - req0, valid_seen);
        end
        do_read(PHY, 5'h0C, 16'h3CA5, 1'b1, 1, 1'b0, "after_reset");
    endtask

    initial begin
        ce    = 1'b0;
        mdi   = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_wrong_phy();
        test_short_pre();
        test_abort_noack();
        test_abort_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdio_frame.md
MDIO_FRAME -- requirements
Module: mdio_frame

Interface
REQ-001 SHALL have parameter: PHY_ADDR, default 5'h00, PHY address this block answers to.
REQ-002 SHALL have port: clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ce  input  1  one-clk strobe per MDC rising edge, from the MDIO pin sampler.
REQ-005 SHALL have port: mdi  input  1  MDIO bit sampled at that MDC edge; valid when ce=1.
REQ-006 SHALL have port: mdo  output  1  bit to drive on MDIO.
REQ-007 SHALL have port: mdo_valid  output  1  request to drive MDIO (pin output enable).
REQ-008 SHALL have port: reg_stb  output  1  register-bus request; held until ack.
REQ-009 SHALL have port: reg_we  output  1  1=write, 0=read; valid with reg_stb.
REQ-010 SHALL have port: reg_addr  output  5  register address; valid with reg_stb.
REQ-011 SHALL have port: reg_wdata  output  16  write data; valid with reg_stb and reg_we=1.
REQ-012 SHALL have port: reg_ack  input  1  one-clk completion of reg_stb.
REQ-013 SHALL have port: reg_err  input  1  qualifies reg_ack; read data is invalid.
REQ-014 SHALL have port: reg_rdata  input  16  read data; valid with reg_ack.

Function
REQ-015 SHALL advance state and sample mdi only in clk cycles with ce=1, except for bus-handshake events.
REQ-016 SHALL have states IDLE, ST, OP, PHYAD, REGAD, TA, DATA, WACK.
REQ-017 IDLE: saturating preamble counter (0..32); mdi=1 increments; mdi=0 with count<32 clears it; mdi=0 with count=32 goes to ST.
REQ-018 ST: mdi=1 goes to OP; mdi=0 goes to IDLE with count cleared.
REQ-019 OP: 2 bits MSB first; 2'b10 = read, 2'b01 = write; 00/11 goes to IDLE, count cleared, no bus activity.
REQ-020 PHYAD and REGAD: 5 bits each, MSB first, counted by a shared 4-bit bit counter.
REQ-021 PHYAD != PHY_ADDR SHALL return to IDLE after PHYAD, count cleared, with no bus or MDIO activity.
REQ-022 Read, at the ce sampling the REGAD LSB: reg_stb=1, reg_we=0, reg_addr=REGAD in the next clk.
REQ-023 Read: reg_stb drops the clk after reg_ack; reg_rdata is latched into the 16-bit shift register unless reg_err=1.
REQ-024 Read TA: first TA bit not driven; the clk after its ce, mdo=0 and mdo_valid=1 if good data is latched.
REQ-025 Read: if data is not latched at the second TA ce (no ack yet, or err), abort: mdo_valid stays 0, stb kept until ack, state goes to IDLE.
REQ-026 Read DATA: each ce, the clk after presents the next bit, MSB first: data[15] after the second TA ce through data[0] after the 15th data ce.
REQ-027 Read: the clk after the 16th data ce, mdo_valid=0 and state goes to IDLE, count cleared.
REQ-028 Write: TA bits are sampled and ignored; 16 data bits are shifted in MSB first.
REQ-029 Write: after the 16th data ce, reg_stb=1, reg_we=1, reg_addr, reg_wdata in the next clk; state goes to WACK.
REQ-030 WACK: ce ignored; on reg_ack (err ignored) drop reg_stb next clk and go to IDLE, count cleared.
REQ-031 mdo/mdo_valid SHALL be registered with 1-clk latency from ce; mdo_valid=1 only in read TA2/DATA.
REQ-032 At most one bus request outstanding; a late read ack after an abort is consumed in IDLE while frame decode continues.
REQ-033 reg_ack with reg_stb=0 SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL asynchronously force IDLE, count 0, bit counter 0, and all outputs 0, including mid-frame and mid-handshake.
REQ-035 After release, a full 32-bit preamble SHALL be required before any frame.

Structure
REQ-036 Opcodes, preamble length 32, and the state encoding SHALL live in the shared MDIO header/package.
REQ-037 No sub-module; a single 16-bit shift register SHALL serve both directions.

Verification
REQ-038 32x'1', ST 01, OP 10, PHYAD=PHY_ADDR, REGAD 5'h02, ack 1 clk later with 16'hABCD -> mdo_valid high from TA2; bits 0,1010101111001101.
REQ-039 Write frame: REGAD 5'h1F, data 16'h1234 -> single reg_stb, we=1, addr 1F, wdata 1234; held until ack; then IDLE.
REQ-040 Read frame to PHYAD^1 -> no reg_stb, mdo_valid never 1; next valid frame decodes correctly.
REQ-041 Only 31 preamble ones before ST -> frame ignored.
REQ-042 Read with no ack until after TA2, or ack with reg_err=1 -> mdo_valid never asserted; state IDLE; stb drops after ack.
REQ-043 rst_n low mid read data bit 7 -> mdo_valid=0, reg_stb=0 immediately; fresh preamble plus frame succeeds.
